// File: rtl/ifid_skid_latch.sv
// IF/ID boundary register: two-entry skid buffer (main + skid) between fetch and decode,
// with taken-branch flush and a saturating decode-stall counter.
module ifid_skid_latch #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [ADDR_W-1:0] if_npc_i,
  input  logic [DATA_W-1:0] if_instr_i,
  input  logic              flush_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [ADDR_W-1:0] id_npc_o,
  output logic [DATA_W-1:0] id_instr_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;
    logic [DATA_W-1:0] instr;
  } word_t;

  state_t            state_q, state_d;
  word_t             main_q, main_d, skid_q, skid_d, in_w;
  logic              if_ready_q, id_valid_q;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_xfer, out_xfer;

  // Handshake flags come only from flops, so id_ready never reaches if_ready combinationally.
  assign in_xfer  = if_valid_i & if_ready_q;
  assign out_xfer = id_valid_q & id_ready_i;
  assign in_w     = '{pc: if_pc_i, npc: if_npc_i, instr: if_instr_i};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    if (id_valid_q && !id_ready_i && !flush_i && !(&stall_q))
      stall_d = stall_q + 1'b1;
    if (flush_i) begin
      // main keeps its contents so id_pc/id_npc hold their last value while invalid
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          state_d = ONE;
          main_d  = in_w;
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d = TWO;
            skid_d  = in_w;
          end else if (in_xfer && out_xfer) begin
            main_d  = in_w;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      if_ready_q <= (state_d != TWO);
      id_valid_q <= (state_d != EMPTY);
      stall_q    <= stall_d;
    end
  end

  assign if_ready_o  = if_ready_q;
  assign id_valid_o  = id_valid_q;
  assign id_pc_o     = main_q.pc;
  assign id_npc_o    = main_q.npc;
  assign id_instr_o  = id_valid_q ? main_q.instr : NOP_INSTR;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_ifid_skid_latch.sv
// Directed bench for ifid_skid_latch: streaming, stall/backpressure, flush, async reset,
// and stall-counter saturation, each step checked against hand-computed values.
module tb_ifid_skid_latch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_valid_i, if_ready_o, flush_i, id_ready_i, id_valid_o;
  logic [31:0] if_pc_i, if_npc_i, if_instr_i, id_pc_o, id_npc_o, id_instr_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  ifid_skid_latch #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_pc_i(if_pc_i), .if_npc_i(if_npc_i), .if_instr_i(if_instr_i),
    .flush_i(flush_i), .id_ready_i(id_ready_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_npc_o(id_npc_o),
    .id_instr_o(id_instr_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid_i = v;
    if_pc_i    = pc;
    if_npc_i   = pc + 32'd4;
    if_instr_i = ins;
  endtask

  // Checks the full ID-side view of a valid word.
  task automatic chk_word(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"}, {63'd0, id_valid_o}, 64'd1);
    chk({tag, ".pc"},    {32'd0, id_pc_o}, {32'd0, pc});
    chk({tag, ".npc"},   {32'd0, id_npc_o}, {32'd0, pc + 32'd4});
    chk({tag, ".instr"}, {32'd0, id_instr_o}, {32'd0, ins});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {63'd0, id_valid_o}, 64'd0);
    chk({tag, ".instr"}, {32'd0, id_instr_o}, {32'd0, NOP});
    chk({tag, ".rdy"},   {63'd0, if_ready_o}, 64'd1);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    chk_empty("rst");
    chk("rst.pc", {32'd0, id_pc_o}, 64'd0);
    chk("rst.cnt", {48'd0, stall_cnt_o}, 64'd0);
    rst_ni = 1'b1;

    // 1: streaming at full rate
    id_ready_i = 1'b1;
    drive(1'b1, 32'h0, 32'hA);  tick(); chk_word("s1.A", 32'h0, 32'hA);
    drive(1'b1, 32'h4, 32'hB);  tick(); chk_word("s1.B", 32'h4, 32'hB);
    drive(1'b1, 32'h8, 32'hC);  tick(); chk_word("s1.C", 32'h8, 32'hC);
    drive(1'b0, 32'h0, 32'h0);  tick(); chk_empty("s1.end");
    chk("s1.pchold", {32'd0, id_pc_o}, 64'h8);

    // 2: backpressure fills skid, fetch held, then in-order drain
    id_ready_i = 1'b0;
    drive(1'b1, 32'h10, 32'h110); tick(); chk_word("s2.10", 32'h10, 32'h110);
    chk("s2.rdy1", {63'd0, if_ready_o}, 64'd1);
    drive(1'b1, 32'h14, 32'h114); tick();
    chk("s2.rdy0", {63'd0, if_ready_o}, 64'd0);
    chk("s2.cnt1", {48'd0, stall_cnt_o}, 64'd1);
    drive(1'b1, 32'h18, 32'h118); tick(); tick();
    chk_word("s2.hold", 32'h10, 32'h110);
    chk("s2.cnt3", {48'd0, stall_cnt_o}, 64'd3);
    id_ready_i = 1'b1;
    tick(); chk_word("s2.14", 32'h14, 32'h114);
    chk("s2.rdy", {63'd0, if_ready_o}, 64'd1);
    tick(); chk_word("s2.18", 32'h18, 32'h118);
    drive(1'b0, 32'h0, 32'h0); tick(); chk_empty("s2.end");
    chk("s2.cnt", {48'd0, stall_cnt_o}, 64'd3);

    // 3: flush while TWO discards held words and the incoming one
    id_ready_i = 1'b0;
    drive(1'b1, 32'h30, 32'h130); tick();
    drive(1'b1, 32'h34, 32'h134); tick();
    chk("s3.cnt4", {48'd0, stall_cnt_o}, 64'd4);
    flush_i = 1'b1;
    drive(1'b1, 32'h20, 32'h120); tick(); chk_empty("s3.flush");
    chk("s3.cnt", {48'd0, stall_cnt_o}, 64'd4);
    flush_i = 1'b0; id_ready_i = 1'b1;
    drive(1'b1, 32'h2, 32'hBEEF); tick(); chk_word("s3.tgt", 32'h2, 32'hBEEF);
    drive(1'b0, 32'h0, 32'h0); tick(); chk_empty("s3.end");

    // 4: flush while ONE with id_ready=1; word delivered once, nothing repeats
    id_ready_i = 1'b0;
    drive(1'b1, 32'h50, 32'h150); tick(); chk_word("s4.50", 32'h50, 32'h150);
    drive(1'b0, 32'h0, 32'h0);
    flush_i = 1'b1; id_ready_i = 1'b1; tick(); chk_empty("s4.flush");
    flush_i = 1'b0; tick(); chk_empty("s4.after");
    chk("s4.cnt", {48'd0, stall_cnt_o}, 64'd4);

    // 5: asynchronous reset mid-cycle while TWO
    id_ready_i = 1'b0;
    drive(1'b1, 32'h60, 32'h160); tick();
    drive(1'b1, 32'h64, 32'h164); tick();
    chk("s5.rdy0", {63'd0, if_ready_o}, 64'd0);
    chk("s5.cnt5", {48'd0, stall_cnt_o}, 64'd5);
    #2 rst_ni = 1'b0;
    #1;
    chk_empty("s5.rst");
    chk("s5.pc", {32'd0, id_pc_o}, 64'd0);
    chk("s5.npc", {32'd0, id_npc_o}, 64'd0);
    chk("s5.cnt", {48'd0, stall_cnt_o}, 64'd0);
    #2 rst_ni = 1'b1;
    id_ready_i = 1'b1;
    drive(1'b1, 32'h40, 32'h140); tick(); chk_word("s5.40", 32'h40, 32'h140);
    drive(1'b0, 32'h0, 32'h0); tick(); chk_empty("s5.end");

    // 6: long stall saturates the counter
    id_ready_i = 1'b0;
    drive(1'b1, 32'h70, 32'h170); tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (65540) tick();
    chk("s6.sat", {48'd0, stall_cnt_o}, 64'hFFFF);
    tick();
    chk("s6.hold", {48'd0, stall_cnt_o}, 64'hFFFF);
    chk_word("s6.word", 32'h70, 32'h170);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
